// File: rtl/led_frame_sequencer.sv
// Frame-synchronous control front-end for led_driver: shadows software config,
// applies it only at frame boundaries, and arbitrates double-buffer ownership.
module led_frame_sequencer #(
  parameter int N_ROWS_MAX     = 64,
  parameter int N_COLS_MAX     = 256,
  parameter int BITDEPTH_MAX   = 8,
  parameter int LSB_BLANK_MAX  = 200,
  parameter int CTRL_REG_WIDTH = 32,
  parameter int RST_CYCLES     = 4
) (
  input  logic                      clk,
  input  logic                      ctrl_rst_n,
  input  logic                      sw_enable,
  input  logic                      sw_cfg_load,
  input  logic [CTRL_REG_WIDTH-1:0] sw_n_rows,
  input  logic [CTRL_REG_WIDTH-1:0] sw_n_cols,
  input  logic [CTRL_REG_WIDTH-1:0] sw_bitdepth,
  input  logic [CTRL_REG_WIDTH-1:0] sw_lsb_blank,
  input  logic [CTRL_REG_WIDTH-1:0] sw_brightness,
  input  logic                      sw_swap_req,
  input  logic                      disp_latch,
  output logic                      drv_en,
  output logic                      drv_rst,
  output logic [CTRL_REG_WIDTH-1:0] drv_n_rows,
  output logic [CTRL_REG_WIDTH-1:0] drv_n_cols,
  output logic [CTRL_REG_WIDTH-1:0] drv_bitdepth,
  output logic [CTRL_REG_WIDTH-1:0] drv_lsb_blank,
  output logic [CTRL_REG_WIDTH-1:0] drv_brightness,
  output logic                      drv_buffer,
  output logic                      swap_done,
  output logic                      swap_pending,
  output logic                      cfg_err,
  output logic                      swap_overrun,
  output logic [15:0]               frame_count
);

  localparam int CW     = CTRL_REG_WIDTH;
  localparam int CNT_W  = $clog2(N_ROWS_MAX * BITDEPTH_MAX);
  localparam int ROW_W  = $clog2(N_ROWS_MAX + 1);
  localparam int BD_W   = $clog2(BITDEPTH_MAX + 1);
  localparam int PROD_W = ROW_W + BD_W;
  localparam int RC_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [CW-1:0] ROWS_MAX  = CW'(N_ROWS_MAX);
  localparam logic [CW-1:0] COLS_MAX  = CW'(N_COLS_MAX);
  localparam logic [CW-1:0] BD_MAX    = CW'(BITDEPTH_MAX);
  localparam logic [CW-1:0] BLANK_MAX = CW'(LSB_BLANK_MAX);
  localparam logic [CW-1:0] DEF_ROWS  = CW'(N_ROWS_MAX / 2);
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_CYCLES - 1);

  typedef enum logic [1:0] {ST_OFF, ST_RESET, ST_RUN} state_t;

  state_t            state, state_next;
  logic [RC_W-1:0]   rst_cnt;
  logic [CW-1:0]     sh_n_rows, sh_n_cols, sh_bitdepth, sh_lsb_blank, sh_brightness;
  logic              geo_pending, bri_pending;
  logic              latch_q, rise_q;
  logic [CNT_W-1:0]  latch_cnt;
  logic [PROD_W-1:0] frame_last;

  logic              cfg_valid, cfg_accept, boundary;
  logic              load_all, load_bri, take_window, take;
  logic              geo_diff, bri_diff;

  assign cfg_valid = (sw_n_rows    != '0) && (sw_n_rows    <= ROWS_MAX)  &&
                     (sw_n_cols    != '0) && (sw_n_cols    <= COLS_MAX)  &&
                     (sw_bitdepth  != '0) && (sw_bitdepth  <= BD_MAX)    &&
                     (sw_lsb_blank != '0) && (sw_lsb_blank <= BLANK_MAX) &&
                     (sw_brightness < sw_lsb_blank);
  assign cfg_accept = sw_cfg_load && cfg_valid;

  // Frame length derives only from the active (registered) geometry.
  assign frame_last = PROD_W'(drv_n_rows[ROW_W-1:0]) * PROD_W'(drv_bitdepth[BD_W-1:0])
                      - PROD_W'(1);
  assign boundary   = (state == ST_RUN) && rise_q && (PROD_W'(latch_cnt) == frame_last);
  assign take       = take_window && (swap_pending || sw_swap_req);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next  = state;
    load_all    = 1'b0;
    load_bri    = 1'b0;
    take_window = 1'b0;
    drv_en      = 1'b0;
    drv_rst     = 1'b1;
    case (state)
      ST_OFF: begin
        take_window = 1'b1;
        if (sw_enable) begin
          load_all   = 1'b1;
          state_next = ST_RESET;
        end
      end
      ST_RESET: begin
        take_window = 1'b1;
        if (!sw_enable)          state_next = ST_OFF;
        else if (rst_cnt == '0)  state_next = ST_RUN;
      end
      ST_RUN: begin
        drv_en  = 1'b1;
        drv_rst = 1'b0;
        if (!sw_enable) begin
          state_next = ST_OFF;
        end else if (boundary) begin
          take_window = 1'b1;
          if (geo_pending) begin
            load_all   = 1'b1;
            state_next = ST_RESET;
          end else if (bri_pending) begin
            load_bri = 1'b1;
          end
        end
      end
      default: state_next = ST_OFF;
    endcase
  end

  // Pending flags compare a new load against the config drv_* will hold next cycle.
  always_comb begin
    geo_diff = (sw_n_rows    != (load_all ? sh_n_rows    : drv_n_rows))   ||
               (sw_n_cols    != (load_all ? sh_n_cols    : drv_n_cols))   ||
               (sw_bitdepth  != (load_all ? sh_bitdepth  : drv_bitdepth)) ||
               (sw_lsb_blank != (load_all ? sh_lsb_blank : drv_lsb_blank));
    bri_diff = sw_brightness != ((load_all || load_bri) ? sh_brightness : drv_brightness);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) state <= ST_OFF;
    else             state <= state_next;
  end

  always_ff @(posedge clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      rst_cnt        <= '0;
      sh_n_rows      <= DEF_ROWS;
      sh_n_cols      <= COLS_MAX;
      sh_bitdepth    <= BD_MAX;
      sh_lsb_blank   <= BLANK_MAX;
      sh_brightness  <= '0;
      drv_n_rows     <= DEF_ROWS;
      drv_n_cols     <= COLS_MAX;
      drv_bitdepth   <= BD_MAX;
      drv_lsb_blank  <= BLANK_MAX;
      drv_brightness <= '0;
      geo_pending    <= 1'b0;
      bri_pending    <= 1'b0;
      cfg_err        <= 1'b0;
      latch_q        <= 1'b0;
      rise_q         <= 1'b0;
      latch_cnt      <= '0;
      frame_count    <= '0;
      drv_buffer     <= 1'b0;
      swap_done      <= 1'b0;
      swap_pending   <= 1'b0;
      swap_overrun   <= 1'b0;
    end else begin
      if (state_next == ST_RESET && state != ST_RESET) rst_cnt <= RC_LOAD;
      else if (state == ST_RESET && rst_cnt != '0)     rst_cnt <= rst_cnt - 1'b1;

      if (sw_cfg_load) cfg_err <= !cfg_valid;
      if (cfg_accept) begin
        sh_n_rows     <= sw_n_rows;
        sh_n_cols     <= sw_n_cols;
        sh_bitdepth   <= sw_bitdepth;
        sh_lsb_blank  <= sw_lsb_blank;
        sh_brightness <= sw_brightness;
      end

      if (load_all) begin
        drv_n_rows     <= sh_n_rows;
        drv_n_cols     <= sh_n_cols;
        drv_bitdepth   <= sh_bitdepth;
        drv_lsb_blank  <= sh_lsb_blank;
        drv_brightness <= sh_brightness;
      end else if (load_bri) begin
        drv_brightness <= sh_brightness;
      end

      if (cfg_accept) begin
        geo_pending <= geo_diff;
        bri_pending <= !geo_diff && bri_diff;
      end else if (load_all) begin
        geo_pending <= 1'b0;
        bri_pending <= 1'b0;
      end else if (load_bri) begin
        bri_pending <= 1'b0;
      end

      latch_q <= disp_latch;
      rise_q  <= disp_latch && !latch_q;
      if (drv_rst)      latch_cnt <= '0;
      else if (rise_q)  latch_cnt <= boundary ? '0 : latch_cnt + 1'b1;
      if (boundary)     frame_count <= frame_count + 16'd1;

      // A request arriving while one is still pending is dropped, not queued.
      swap_done <= take;
      if (take)              drv_buffer <= !drv_buffer;
      if (take)              swap_pending <= 1'b0;
      else if (sw_swap_req)  swap_pending <= 1'b1;
      if (sw_swap_req && swap_pending) swap_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed bench for led_frame_sequencer: enable/reset timing, frame-boundary
// config apply, validation, double-buffer swap and asynchronous reset.
module tb_led_frame_sequencer;

  logic        clk = 1'b0;
  logic        ctrl_rst_n;
  logic        sw_enable, sw_cfg_load, sw_swap_req, disp_latch;
  logic [31:0] sw_n_rows, sw_n_cols, sw_bitdepth, sw_lsb_blank, sw_brightness;
  logic        drv_en, drv_rst, drv_buffer, swap_done, swap_pending, cfg_err, swap_overrun;
  logic [31:0] drv_n_rows, drv_n_cols, drv_bitdepth, drv_lsb_blank, drv_brightness;
  logic [15:0] frame_count;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  logic saw_rst;

  always #5 clk = ~clk;

  led_frame_sequencer dut (
    .clk(clk), .ctrl_rst_n(ctrl_rst_n), .sw_enable(sw_enable), .sw_cfg_load(sw_cfg_load),
    .sw_n_rows(sw_n_rows), .sw_n_cols(sw_n_cols), .sw_bitdepth(sw_bitdepth),
    .sw_lsb_blank(sw_lsb_blank), .sw_brightness(sw_brightness), .sw_swap_req(sw_swap_req),
    .disp_latch(disp_latch), .drv_en(drv_en), .drv_rst(drv_rst),
    .drv_n_rows(drv_n_rows), .drv_n_cols(drv_n_cols), .drv_bitdepth(drv_bitdepth),
    .drv_lsb_blank(drv_lsb_blank), .drv_brightness(drv_brightness), .drv_buffer(drv_buffer),
    .swap_done(swap_done), .swap_pending(swap_pending), .cfg_err(cfg_err),
    .swap_overrun(swap_overrun), .frame_count(frame_count)
  );

  always @(negedge clk) if (swap_done === 1'b1) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic latch_edge();
    disp_latch = 1'b1;
    step();
    saw_rst |= drv_rst;
    disp_latch = 1'b0;
    step();
    saw_rst |= drv_rst;
  endtask

  task automatic latch_edges(input int n);
    for (int i = 0; i < n; i++) latch_edge();
  endtask

  task automatic cfg_load(input int r, input int c, input int b, input int bl, input int br);
    sw_n_rows = r; sw_n_cols = c; sw_bitdepth = b; sw_lsb_blank = bl; sw_brightness = br;
    sw_cfg_load = 1'b1;
    step();
    sw_cfg_load = 1'b0;
  endtask

  task automatic swap_pulse();
    sw_swap_req = 1'b1;
    step();
    sw_swap_req = 1'b0;
  endtask

  task automatic test_reset();
    ctrl_rst_n = 1'b0;
    step();
    vectors++; if (drv_en !== 1'b0 || drv_rst !== 1'b1) begin miscompares++;
      $display("FAIL rst_ctrl: en=%0d rst=%0d want en=0 rst=1", drv_en, drv_rst); end
    vectors++; if (drv_n_rows !== 32 || drv_n_cols !== 256 || drv_bitdepth !== 8 ||
                   drv_lsb_blank !== 200 || drv_brightness !== 0) begin miscompares++;
      $display("FAIL rst_cfg: %0d/%0d/%0d/%0d/%0d want 32/256/8/200/0", drv_n_rows,
               drv_n_cols, drv_bitdepth, drv_lsb_blank, drv_brightness); end
    vectors++; if ({drv_buffer, swap_done, swap_pending, cfg_err, swap_overrun} !== 5'b0 ||
                   frame_count !== 16'd0) begin miscompares++;
      $display("FAIL rst_flags: buf/done/pend/err/ovr=%b fc=%0d want 0", {drv_buffer,
               swap_done, swap_pending, cfg_err, swap_overrun}, frame_count); end
    ctrl_rst_n = 1'b1;
    step(); step();
    vectors++; if (drv_rst !== 1'b1 || drv_en !== 1'b0) begin miscompares++;
      $display("FAIL off_idle: en=%0d rst=%0d want en=0 rst=1", drv_en, drv_rst); end
  endtask

  task automatic test_enable();
    int rst_seen = 0;
    sw_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (drv_rst === 1'b1 && drv_en === 1'b0) rst_seen++;
    end
    vectors++; if (rst_seen != 4) begin miscompares++;
      $display("FAIL reset_len: %0d cycles in reset, want 4", rst_seen); end
    step();
    vectors++; if (drv_en !== 1'b1 || drv_rst !== 1'b0) begin miscompares++;
      $display("FAIL run_entry: en=%0d rst=%0d want en=1 rst=0", drv_en, drv_rst); end
    vectors++; if (drv_n_rows !== 32 || drv_bitdepth !== 8) begin miscompares++;
      $display("FAIL run_cfg: rows=%0d bd=%0d want 32/8", drv_n_rows, drv_bitdepth); end
  endtask

  task automatic test_geometry();
    int rst_seen = 0;
    cfg_load(4, 8, 2, 200, 0);
    saw_rst = 1'b0;
    latch_edges(255);
    vectors++; if (saw_rst !== 1'b0 || drv_n_rows !== 32 || frame_count !== 0) begin
      miscompares++; $display("FAIL geo_hold: rst_seen=%0d rows=%0d fc=%0d want 0/32/0",
                              saw_rst, drv_n_rows, frame_count); end
    latch_edge();
    vectors++; if (drv_rst !== 1'b1 || frame_count !== 1) begin miscompares++;
      $display("FAIL geo_boundary: rst=%0d fc=%0d want 1/1", drv_rst, frame_count); end
    vectors++; if (drv_n_rows !== 4 || drv_n_cols !== 8 || drv_bitdepth !== 2) begin
      miscompares++; $display("FAIL geo_apply: %0d/%0d/%0d want 4/8/2", drv_n_rows,
                              drv_n_cols, drv_bitdepth); end
    for (int i = 0; i < 3; i++) begin
      step();
      if (drv_rst === 1'b1) rst_seen++;
    end
    step();
    vectors++; if (rst_seen != 3 || drv_en !== 1'b1) begin miscompares++;
      $display("FAIL geo_reset_len: extra=%0d en=%0d want 3/1", rst_seen, drv_en); end
    latch_edges(7);
    vectors++; if (frame_count !== 1) begin miscompares++;
      $display("FAIL frame_7: fc=%0d want 1", frame_count); end
    latch_edge();
    vectors++; if (frame_count !== 2) begin miscompares++;
      $display("FAIL frame_8: fc=%0d want 2", frame_count); end
    latch_edges(8);
    vectors++; if (frame_count !== 3) begin miscompares++;
      $display("FAIL frame_16: fc=%0d want 3", frame_count); end
  endtask

  task automatic test_brightness();
    cfg_load(4, 8, 2, 200, 5);
    saw_rst = 1'b0;
    latch_edges(7);
    vectors++; if (drv_brightness !== 0) begin miscompares++;
      $display("FAIL bri_hold: bri=%0d want 0", drv_brightness); end
    latch_edge();
    vectors++; if (drv_brightness !== 5 || frame_count !== 4) begin miscompares++;
      $display("FAIL bri_apply: bri=%0d fc=%0d want 5/4", drv_brightness, frame_count); end
    vectors++; if (saw_rst !== 1'b0) begin miscompares++;
      $display("FAIL bri_no_rst: drv_rst seen=%0d want 0", saw_rst); end
  endtask

  task automatic test_invalid();
    cfg_load(4, 8, 9, 200, 0);
    vectors++; if (cfg_err !== 1'b1) begin miscompares++;
      $display("FAIL err_bitdepth: cfg_err=%0d want 1", cfg_err); end
    cfg_load(4, 8, 2, 200, 200);
    vectors++; if (cfg_err !== 1'b1) begin miscompares++;
      $display("FAIL err_bright: cfg_err=%0d want 1", cfg_err); end
    saw_rst = 1'b0;
    latch_edges(8);
    vectors++; if (saw_rst !== 1'b0 || drv_bitdepth !== 2 || drv_brightness !== 5 ||
                   frame_count !== 5) begin miscompares++;
      $display("FAIL err_unchanged: rst=%0d bd=%0d bri=%0d fc=%0d want 0/2/5/5", saw_rst,
               drv_bitdepth, drv_brightness, frame_count); end
    cfg_load(4, 8, 2, 200, 5);
    vectors++; if (cfg_err !== 1'b0) begin miscompares++;
      $display("FAIL err_clear: cfg_err=%0d want 0", cfg_err); end
  endtask

  task automatic test_swap();
    int done0;
    swap_pulse();
    vectors++; if (swap_pending !== 1'b1 || swap_overrun !== 1'b0) begin miscompares++;
      $display("FAIL swap_accept: pend=%0d ovr=%0d want 1/0", swap_pending, swap_overrun); end
    swap_pulse();
    vectors++; if (swap_overrun !== 1'b1 || swap_pending !== 1'b1) begin miscompares++;
      $display("FAIL swap_overrun: ovr=%0d pend=%0d want 1/1", swap_overrun, swap_pending); end
    done0 = done_cnt;
    latch_edges(7);
    vectors++; if (drv_buffer !== 1'b0 || done_cnt != done0) begin miscompares++;
      $display("FAIL swap_hold: buf=%0d dones=%0d want 0/0", drv_buffer, done_cnt - done0); end
    latch_edges(1);
    step();
    vectors++; if (drv_buffer !== 1'b1 || swap_pending !== 1'b0 || done_cnt != done0 + 1 ||
                   frame_count !== 6) begin miscompares++;
      $display("FAIL swap_take: buf=%0d pend=%0d dones=%0d fc=%0d want 1/0/1/6", drv_buffer,
               swap_pending, done_cnt - done0, frame_count); end
  endtask

  task automatic test_swap_idle();
    sw_enable = 1'b0;
    step();
    vectors++; if (drv_en !== 1'b0 || drv_rst !== 1'b1) begin miscompares++;
      $display("FAIL off_immediate: en=%0d rst=%0d want 0/1", drv_en, drv_rst); end
    swap_pulse();
    vectors++; if (drv_buffer !== 1'b0 || swap_pending !== 1'b0) begin miscompares++;
      $display("FAIL swap_off_1: buf=%0d pend=%0d want 0/0", drv_buffer, swap_pending); end
    swap_pulse();
    vectors++; if (drv_buffer !== 1'b1) begin miscompares++;
      $display("FAIL swap_off_2: buf=%0d want 1", drv_buffer); end
  endtask

  task automatic test_reset_mid();
    sw_enable = 1'b1;
    step(); step();
    vectors++; if (drv_rst !== 1'b1 || drv_n_rows !== 4 || drv_brightness !== 5) begin
      miscompares++; $display("FAIL reenable: rst=%0d rows=%0d bri=%0d want 1/4/5", drv_rst,
                              drv_n_rows, drv_brightness); end
    sw_swap_req = 1'b1;
    ctrl_rst_n  = 1'b0;
    #1;
    vectors++; if (drv_buffer !== 1'b0 || swap_pending !== 1'b0 || swap_overrun !== 1'b0 ||
                   frame_count !== 0 || drv_en !== 1'b0 || drv_rst !== 1'b1) begin
      miscompares++; $display("FAIL async_rst: buf=%0d pend=%0d ovr=%0d fc=%0d en=%0d rst=%0d",
                              drv_buffer, swap_pending, swap_overrun, frame_count, drv_en, drv_rst);
    end
    vectors++; if (drv_n_rows !== 32 || drv_brightness !== 0) begin miscompares++;
      $display("FAIL async_rst_cfg: rows=%0d bri=%0d want 32/0", drv_n_rows, drv_brightness); end
    sw_swap_req = 1'b0;
    sw_enable   = 1'b0;
    step();
    ctrl_rst_n = 1'b1;
    step();
  endtask

  initial begin
    ctrl_rst_n = 1'b0; sw_enable = 1'b0; sw_cfg_load = 1'b0; sw_swap_req = 1'b0;
    disp_latch = 1'b0; saw_rst = 1'b0;
    sw_n_rows = 0; sw_n_cols = 0; sw_bitdepth = 0; sw_lsb_blank = 0; sw_brightness = 0;
    test_reset();
    test_enable();
    test_geometry();
    test_brightness();
    test_invalid();
    test_swap();
    test_swap_idle();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
